karatsuba_pp_seq: RTL and testbench



---
 rtl/karatsuba_pp_seq.sv | 155 +++++++++++++++
 tb/tb_karatsuba_pp_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_pp_seq.sv
// karatsuba_pp_seq
// Sequential carry-less (GF(2)) partial-product generator for a 64x64 Karatsuba
// polynomial multiplier. Splits a and b into 32-bit halves and produces three
// 63-bit carry-less products with three digit-serial engines running in lockstep:
//   z0 = a_lo * b_lo
//   z1 = (a_lo ^ a_hi) * (b_lo ^ b_hi)
//   z2 = a_hi * b_hi
// Each engine consumes DIGIT multiplier bits per cycle, MSB-first.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE)
//   a, b       64-bit operands; [63:32] = hi half, [31:0] = lo half
//   out_valid  z0/z1/z2 valid (DONE)
//   out_ready  downstream accepts the result
//   z0/z1/z2   63-bit carry-less products, held until the next result
//   busy       high while the engines are working
module karatsuba_pp_seq #(
  parameter int unsigned DIGIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [62:0] z0,
  output logic [62:0] z1,
  output logic [62:0] z2,
  output logic        busy
);

  localparam int unsigned STEPS = 32 / DIGIT;
  // Counter runs 0..STEPS; the extra count is the commit cycle into the z registers.
  localparam int unsigned CntW  = $clog2(STEPS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(STEPS);

  // Only digit widths that divide 32 evenly as powers of two are supported.
  if (!(DIGIT == 1 || DIGIT == 2 || DIGIT == 4 || DIGIT == 8 ||
        DIGIT == 16 || DIGIT == 32)) begin : gen_bad_digit
    $error("karatsuba_pp_seq: DIGIT must be one of 1, 2, 4, 8, 16, 32");
  end

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      step_q, step_d;
  // Index 0 -> z0 pair, 1 -> z1 pair, 2 -> z2 pair.
  logic [2:0][31:0]     m_q, m_d;    // multiplicands
  logic [2:0][31:0]     n_q, n_d;    // multipliers, shifted left as digits are consumed
  logic [2:0][62:0]     acc_q, acc_d;
  logic [2:0][62:0]     z_q, z_d;

  // One Horner step: shift the running product up one digit and add the
  // digit-by-multiplicand partial product, all in GF(2).
  function automatic logic [62:0] clmul_step(input logic [62:0]      acc,
                                             input logic [31:0]      m,
                                             input logic [DIGIT-1:0] d);
    logic [62:0] pp;
    pp = '0;
    for (int j = 0; j < int'(DIGIT); j++) begin
      if (d[j]) begin
        pp = pp ^ ({31'b0, m} << j);
      end
    end
    return (acc << DIGIT) ^ pp;
  endfunction

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    m_d     = m_q;
    n_d     = n_q;
    acc_d   = acc_q;
    z_d     = z_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          m_d[0]  = a[31:0];
          n_d[0]  = b[31:0];
          m_d[1]  = a[31:0] ^ a[63:32];
          n_d[1]  = b[31:0] ^ b[63:32];
          m_d[2]  = a[63:32];
          n_d[2]  = b[63:32];
          acc_d   = '0;
          step_d  = '0;
          state_d = StBusy;
        end
      end

      StBusy: begin
        if (step_q == LastCnt) begin
          // All digits consumed: publish the finished products in one shot so
          // no partial accumulator value ever reaches z0/z1/z2.
          z_d     = acc_q;
          state_d = StDone;
        end else begin
          for (int i = 0; i < 3; i++) begin
            acc_d[i] = clmul_step(acc_q[i], m_q[i], n_q[i][31 -: DIGIT]);
            n_d[i]   = n_q[i] << DIGIT;
          end
          step_d = step_q + CntW'(1);
        end
      end

      StDone: begin
        // Leaving DONE never accepts a new operand in the same cycle.
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      step_q  <= '0;
      m_q     <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      m_q     <= m_d;
      n_q     <= n_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StBusy);
    out_valid = (state_q == StDone);
    z0        = z_q[0];
    z1        = z_q[1];
    z2        = z_q[2];
  end

endmodule

// File: tb/tb_karatsuba_pp_seq.sv
module tb_karatsuba_pp_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [62:0] z0, z1, z2;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  localparam int Latency = 9;  // DIGIT = 4
  localparam int Timeout = 200;

  karatsuba_pp_seq #(.DIGIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z0        (z0),
    .z1        (z1),
    .z2        (z2),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Bitwise carry-less reference: bit i of x times bit j of y lands on bit i+j.
  function automatic logic [62:0] clmul32(input logic [31:0] x, input logic [31:0] y);
    logic [62:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        if (x[i] && y[j]) r[i+j] = ~r[i+j];
      end
    end
    return r;
  endfunction

  // Present operands for one cycle; returns #1 after the accepting edge with
  // garbage on a/b so any later dependency on them shows up.
  task automatic start_op(input logic [63:0] av, input logic [63:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~av;
    b = {bv[31:0], bv[63:32]} ^ 64'hA5A5_5A5A_0FF0_F00F;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < Timeout) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Handshake the result away and return #1 after the edge that leaves DONE.
  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, busy, in_ready} !== 3'b001 || {z0, z1, z2} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: out_valid=%b busy=%b in_ready=%b z0=%h z1=%h z2=%h, want 0 0 1 zeros",
               out_valid, busy, in_ready, z0, z1, z2);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_products();
    logic [63:0] va [4];
    logic [63:0] vb [4];
    logic [62:0] e0 [4];
    logic [62:0] e1 [4];
    logic [62:0] e2 [4];
    int lat;
    va[0] = 64'h00000003_00000002; vb[0] = 64'h00000005_00000007;
    e0[0] = 63'hE; e1[0] = 63'h2; e2[0] = 63'hF;
    va[1] = 64'hFFFFFFFF_FFFFFFFF; vb[1] = 64'hFFFFFFFF_FFFFFFFF;
    e0[1] = 63'h5555_5555_5555_5555; e1[1] = 63'h0; e2[1] = 63'h5555_5555_5555_5555;
    va[2] = 64'h80000000_80000000; vb[2] = 64'h80000000_00000001;
    e0[2] = 63'h8000_0000; e1[2] = 63'h0; e2[2] = 63'h4000_0000_0000_0000;
    va[3] = 64'h0000000F_000000F0; vb[3] = 64'h00000001_00000003;
    e0[3] = 63'h110; e1[3] = 63'h1FE; e2[3] = 63'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start_op(va[k], vb[k]);
      tests_run++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL products_busy[%0d]: busy=%b in_ready=%b, want 1 0", k, busy, in_ready);
      end
      wait_valid(lat);
      tests_run++;
      if (lat != Latency) begin
        tests_failed++;
        $display("FAIL products_latency[%0d]: got %0d cycles, want %0d", k, lat, Latency);
      end
      tests_run++;
      if (z0 !== e0[k] || z1 !== e1[k] || z2 !== e2[k]) begin
        tests_failed++;
        $display("FAIL products_value[%0d]: z0=%h z1=%h z2=%h, want %h %h %h",
                 k, z0, z1, z2, e0[k], e1[k], e2[k]);
      end
      // out_ready already high: DONE lasts exactly one cycle.
      @(posedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL products_release[%0d]: out_valid=%b in_ready=%b, want 0 1",
                 k, out_valid, in_ready);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [63:0] ya, yb;
    ya = 64'h00000003_00000002;
    yb = 64'h00000005_00000007;
    start_op(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF);
    wait_valid(lat);
    tests_run++;
    if (lat != Latency) begin
      tests_failed++;
      $display("FAIL bp_latency: got %0d cycles, want %0d", lat, Latency);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = ya;
      b = yb;
      @(posedge clk);
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
          z0 !== 63'h5555_5555_5555_5555 || z1 !== 63'h0 ||
          z2 !== 63'h5555_5555_5555_5555) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b busy=%b z0=%h z1=%h z2=%h, want 1 0 0 5555.. 0 5555..",
                 c, out_valid, in_ready, busy, z0, z1, z2);
      end
    end
    // Release with in_valid still high: must not be taken in the DONE cycle.
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b, want 0 1 0",
               out_valid, in_ready, busy);
    end
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = '1;
    b = '0;
    tests_run++;
    if (busy !== 1'b1 || z0 !== 63'h5555_5555_5555_5555) begin
      tests_failed++;
      $display("FAIL bp_next_accept: busy=%b z0=%h, want 1 5555555555555555", busy, z0);
    end
    wait_valid(lat);
    tests_run++;
    if (lat != Latency || z0 !== 63'hE || z1 !== 63'h2 || z2 !== 63'hF) begin
      tests_failed++;
      $display("FAIL bp_next_result: lat=%0d z0=%h z1=%h z2=%h, want %0d e 2 f",
               lat, z0, z1, z2, Latency);
    end
    drain();
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    start_op(64'h80000000_80000000, 64'h80000000_00000001);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || {z0, z1, z2} !== '0) begin
      tests_failed++;
      $display("FAIL rst_busy_clear: out_valid=%b busy=%b z0=%h z1=%h z2=%h, want 0 0 zeros",
               out_valid, busy, z0, z1, z2);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_busy_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
    start_op(64'h0000000F_000000F0, 64'h00000001_00000003);
    wait_valid(lat);
    tests_run++;
    if (lat != Latency || z0 !== 63'h110 || z1 !== 63'h1FE || z2 !== 63'hF) begin
      tests_failed++;
      $display("FAIL rst_busy_next: lat=%0d z0=%h z1=%h z2=%h, want %0d 110 1fe f",
               lat, z0, z1, z2, Latency);
    end
    drain();
  endtask

  task automatic test_random();
    int lat;
    logic [63:0] ra, rb;
    logic [62:0] e0, e1, e2;
    for (int k = 0; k < 16; k++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      e0 = clmul32(ra[31:0], rb[31:0]);
      e1 = clmul32(ra[31:0] ^ ra[63:32], rb[31:0] ^ rb[63:32]);
      e2 = clmul32(ra[63:32], rb[63:32]);
      start_op(ra, rb);
      wait_valid(lat);
      tests_run++;
      if (lat != Latency || z0 !== e0 || z1 !== e1 || z2 !== e2) begin
        tests_failed++;
        $display("FAIL random[%0d] a=%h b=%h: lat=%0d z0=%h z1=%h z2=%h, want %0d %h %h %h",
                 k, ra, rb, lat, z0, z1, z2, Latency, e0, e1, e2);
      end
      drain();
    end
  endtask

  initial begin
    test_reset();
    test_products();
    test_backpressure();
    test_reset_mid_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
